intr_source_cond: RTL and testbench

//  Upstream stage of the 16-source priority interrupt controller. Synchronises raw asynchronous

---
 rtl/intr_source_cond.sv | 162 ++++++++++++++++
 tb/tb_intr_source_cond.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/intr_source_cond.sv
// Interrupt source conditioning: synchroniser, level/edge detect, pending latch, mask, APB regs.
// Optional `INTR_POLARITY_EN adds a per-source polarity register at 0x08/0x09.
module intr_source_cond #(
  parameter int NUM_INTR    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        pclk_i,
  input  logic        prst_n_i,
  input  logic [7:0]  paddr_i,
  input  logic [7:0]  pwdata_i,
  output logic [7:0]  prdata_o,
  input  logic        pwrite_i,
  input  logic        penable_i,
  output logic        pready_o,
  output logic        perror_o,
  input  logic [15:0] irq_raw_i,
  output logic [15:0] intr_active_o,
  input  logic [3:0]  intr_to_service_i,
  input  logic        intr_serviced_i
);

  localparam logic [15:0] VALID = 16'((32'd1 << NUM_INTR) - 32'd1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_WAIT_DROP} apb_state_e;

  apb_state_e state_q, state_d;

  logic [SYNC_STAGES-1:0][15:0] sync_q;
  logic [15:0] hist_q;
  logic [15:0] mask_q, mask_d;
  logic [15:0] mode_q, mode_d;
  logic [15:0] pend_q, pend_d;
  logic [15:0] active_q;
  logic [7:0]  prdata_q, prdata_d;
  logic        perror_q, perror_d;

  logic [15:0] raw_in, s_last, edge_det;
  logic [15:0] rd_word, wr_word, byte_mask;
  logic [15:0] w1c, svc_clr, to_edge, pend_edge;
  logic [7:0]  rd_byte;
  logic        access, mapped, read_only, acc_err, wr_commit;
  logic        wr_mask, wr_mode, wr_pend;

`ifdef INTR_POLARITY_EN
  logic [15:0] pol_q, pol_d;
  logic        wr_pol;
  assign raw_in = (irq_raw_i ^ pol_q) & VALID;
`else
  assign raw_in = irq_raw_i & VALID;
`endif

  assign s_last   = sync_q[SYNC_STAGES-1];
  assign edge_det = s_last & ~hist_q;

  // ---------------- APB access decode ----------------
  assign access = (state_q == ST_IDLE) && penable_i;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    mapped    = 1'b1;
    read_only = 1'b0;
    rd_word   = '0;
    case (paddr_i[7:1])
      7'h00:   rd_word = mask_q;
      7'h01:   rd_word = mode_q;
      7'h02:   rd_word = pend_q;
      7'h03: begin
        rd_word   = s_last;
        read_only = 1'b1;
      end
`ifdef INTR_POLARITY_EN
      7'h04:   rd_word = pol_q;
`endif
      default: mapped = 1'b0;
    endcase
  end

  assign rd_byte   = paddr_i[0] ? rd_word[15:8] : rd_word[7:0];
  assign acc_err   = !mapped || (pwrite_i && read_only);
  assign wr_commit = access && pwrite_i && !acc_err;
  assign byte_mask = paddr_i[0] ? 16'hFF00 : 16'h00FF;
  assign wr_word   = {pwdata_i, pwdata_i} & byte_mask;

  assign wr_mask = wr_commit && (paddr_i[7:1] == 7'h00);
  assign wr_mode = wr_commit && (paddr_i[7:1] == 7'h01);
  assign wr_pend = wr_commit && (paddr_i[7:1] == 7'h02);

  assign mask_d = wr_mask ? (((mask_q & ~byte_mask) | wr_word) & VALID) : mask_q;
  assign mode_d = wr_mode ? (((mode_q & ~byte_mask) | wr_word) & VALID) : mode_q;
`ifdef INTR_POLARITY_EN
  assign wr_pol = wr_commit && (paddr_i[7:1] == 7'h04);
  assign pol_d  = wr_pol ? (((pol_q & ~byte_mask) | wr_word) & VALID) : pol_q;
`endif

  assign prdata_d = (access && !pwrite_i && !acc_err) ? rd_byte : 8'h00;
  assign perror_d = access && acc_err;

  // ---------------- pending latch ----------------
  // Edge sources: set beats clear. Sources switching level->edge drop PEND and wait for a new edge.
  assign w1c       = wr_pend ? wr_word : 16'h0000;
  assign svc_clr   = intr_serviced_i ? (16'h0001 << intr_to_service_i) : 16'h0000;
  assign to_edge   = mode_d & ~mode_q;
  assign pend_edge = edge_det | (pend_q & ~(w1c | svc_clr));

  always_comb begin
    pend_d = (mode_q & pend_edge) | (~mode_q & s_last);
    pend_d = ((pend_d & ~to_edge) | (edge_det & to_edge)) & VALID;
  end

  // ---------------- APB FSM ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (penable_i)  state_d = ST_ACK;
      ST_ACK:       state_d = penable_i ? ST_WAIT_DROP : ST_IDLE;
      ST_WAIT_DROP: if (!penable_i) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pready_o = (state_q == ST_ACK);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      state_q  <= ST_IDLE;
      sync_q   <= '0;
      hist_q   <= '0;
      mask_q   <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
      active_q <= '0;
      prdata_q <= '0;
      perror_q <= 1'b0;
`ifdef INTR_POLARITY_EN
      pol_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_in};
      hist_q   <= s_last;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      active_q <= pend_q & mask_q;
      if (access) begin
        prdata_q <= prdata_d;
        perror_q <= perror_d;
      end
`ifdef INTR_POLARITY_EN
      pol_q    <= pol_d;
`endif
    end
  end

  assign prdata_o      = prdata_q;
  assign perror_o      = perror_q;
  assign intr_active_o = active_q;

endmodule

// File: tb/tb_intr_source_cond.sv
// Directed bench for intr_source_cond: register table plus hand-built interrupt sequences.
module tb_intr_source_cond;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  paddr, pwdata, prdata;
  logic        pwrite, penable, pready, perror;
  logic [15:0] irq_raw, intr_active;
  logic [3:0]  to_service;
  logic        serviced;

  int tests = 0;
  int fails = 0;

  intr_source_cond dut (
    .pclk_i            (clk),
    .prst_n_i          (rst_n),
    .paddr_i           (paddr),
    .pwdata_i          (pwdata),
    .prdata_o          (prdata),
    .pwrite_i          (pwrite),
    .penable_i         (penable),
    .pready_o          (pready),
    .perror_o          (perror),
    .irq_raw_i         (irq_raw),
    .intr_active_o     (intr_active),
    .intr_to_service_i (to_service),
    .intr_serviced_i   (serviced)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                     input logic [7:0] rd, input logic er);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.exp_rd = rd; v.exp_err = er;
    vecs.push_back(v);
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // One complete access; waits out the ACK cycle so the next access starts from IDLE.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                      output logic [7:0] rd, output logic er);
    int n;
    @(negedge clk);
    paddr = a; pwdata = wd; pwrite = wr; penable = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!pready && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (!pready) check("pready_timeout", 32'(pready), 32'd1);
    rd = prdata; er = perror;
    penable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] rd;
    logic       er;
    xfer(1'b1, a, d, rd, er);
    check($sformatf("wr_err_%02h", a), 32'(er), 32'd0);
  endtask

  task automatic rd_reg(input string name, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] rd;
    logic       er;
    xfer(1'b0, a, 8'h00, rd, er);
    check(name, 32'(rd), 32'(exp));
  endtask

  initial begin
    logic [7:0] rd;
    logic       er;
    int         rdy_cnt;

    rst_n = 1'b0; paddr = '0; pwdata = '0; pwrite = 1'b0; penable = 1'b0;
    irq_raw = '0; to_service = '0; serviced = 1'b0;

    for (int a = 0; a < 8; a++) add(1'b0, 8'(a), 8'h00, 8'h00, 1'b0);
    add(1'b0, 8'h0A, 8'h00, 8'h00, 1'b1);
`ifdef INTR_POLARITY_EN
    add(1'b0, 8'h08, 8'h00, 8'h00, 1'b0);
`else
    add(1'b0, 8'h08, 8'h00, 8'h00, 1'b1);
`endif
    add(1'b1, 8'h06, 8'h55, 8'h00, 1'b1);   // SYNC status is read-only
    add(1'b1, 8'h20, 8'h55, 8'h00, 1'b1);
    add(1'b1, 8'h02, 8'h3C, 8'h00, 1'b0);
    add(1'b0, 8'h02, 8'h00, 8'h3C, 1'b0);
    add(1'b1, 8'h02, 8'h00, 8'h00, 1'b0);
    add(1'b1, 8'h00, 8'hFF, 8'h00, 1'b0);
    add(1'b1, 8'h01, 8'hFF, 8'h00, 1'b0);
    add(1'b0, 8'h00, 8'h00, 8'hFF, 1'b0);
    add(1'b0, 8'h01, 8'h00, 8'hFF, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_perror", 32'(perror), 32'd0);
    check("rst_prdata", 32'(prdata), 32'd0);
    check("rst_active", 32'(intr_active), 32'd0);

    foreach (vecs[i]) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_rd", i), 32'(rd), 32'(vecs[i].exp_rd));
    end

    // Level source latency: raw change reaches intr_active after exactly 4 edges.
    @(negedge clk) irq_raw[3] = 1'b1;
    edges(3);
    check("lvl_rise_e3", 32'(intr_active), 32'h0000);
    edges(1);
    check("lvl_rise_e4", 32'(intr_active), 32'h0008);
    @(negedge clk) serviced = 1'b1; to_service = 4'd3;
    @(negedge clk) serviced = 1'b0;
    edges(2);
    check("lvl_ignores_service", 32'(intr_active), 32'h0008);
    @(negedge clk) irq_raw[3] = 1'b0;
    edges(3);
    check("lvl_fall_e3", 32'(intr_active), 32'h0008);
    edges(1);
    check("lvl_fall_e4", 32'(intr_active), 32'h0000);

    // Edge source holds after a short pulse, cleared by service handshake.
    wr_reg(8'h02, 8'h20);
    @(negedge clk) irq_raw[5] = 1'b1;
    @(negedge clk);
    @(negedge clk) irq_raw[5] = 1'b0;
    edges(6);
    check("edge_held", 32'(intr_active), 32'h0020);
    @(negedge clk) serviced = 1'b1; to_service = 4'd5;
    @(negedge clk) serviced = 1'b0;
    edges(1);
    check("edge_serviced", 32'(intr_active), 32'h0000);
    rd_reg("edge_serviced_pend", 8'h04, 8'h00);

    // Masked edge source keeps PEND; unmask exposes it; W1C clears it.
    wr_reg(8'h02, 8'hA0);
    wr_reg(8'h00, 8'h7F);
    @(negedge clk) irq_raw[7] = 1'b1;
    @(negedge clk);
    @(negedge clk) irq_raw[7] = 1'b0;
    edges(6);
    check("masked_active", 32'(intr_active), 32'h0000);
    rd_reg("masked_pend", 8'h04, 8'h80);
    wr_reg(8'h00, 8'hFF);
    edges(1);
    check("unmasked_active", 32'(intr_active), 32'h0080);
    wr_reg(8'h04, 8'h80);
    rd_reg("w1c_pend", 8'h04, 8'h00);
    check("w1c_active", 32'(intr_active), 32'h0000);

    // Set and service-clear of source 2 on the same edge: set wins.
    wr_reg(8'h02, 8'hA4);
    @(negedge clk) irq_raw[2] = 1'b1;
    @(negedge clk);
    @(negedge clk) serviced = 1'b1; to_service = 4'd2;
    @(negedge clk) serviced = 1'b0;
    rd_reg("set_wins_pend", 8'h04, 8'h04);
    @(negedge clk) irq_raw[2] = 1'b0;

    // penable held 3 cycles: one pready pulse, one write.
    @(negedge clk);
    paddr = 8'h03; pwdata = 8'h81; pwrite = 1'b1; penable = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (pready) rdy_cnt++;
    end
    @(negedge clk) penable = 1'b0;
    check("held_pready_count", 32'(rdy_cnt), 32'd1);
    edges(1);
    check("held_pready_low", 32'(pready), 32'd0);
    rd_reg("held_write_data", 8'h03, 8'h81);

`ifdef INTR_POLARITY_EN
    // Active-low source 1 in level mode.
    wr_reg(8'h02, 8'h00);
    wr_reg(8'h03, 8'h00);
    @(negedge clk) irq_raw[1] = 1'b1;
    wr_reg(8'h08, 8'h02);
    edges(6);
    check("pol_idle", 32'(intr_active[1]), 32'd0);
    @(negedge clk) irq_raw[1] = 1'b0;
    edges(4);
    check("pol_active", 32'(intr_active[1]), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
